// File: rtl/aes_link_pkg.sv
// Shared types and sizing helpers for the AES SPI link frame engines.
package aes_link_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX        = 3'd1,
        START     = 3'd2,
        WAIT_CORE = 3'd3,
        TX        = 3'd4,
        DONE      = 3'd5
    } state_e;

    // Serial frame length: one data block followed by the key.
    function automatic int unsigned frame_w(input int unsigned nk);
        return BLOCK_W + nk * 32;
    endfunction

endpackage

// File: rtl/spi_aes_slave_frame_if.sv
// SPI pins plus cipher-core handshake seen by one slave frame engine.
interface spi_aes_slave_frame_if #(
    parameter int unsigned Nk = 4
);
    localparam int unsigned KEY_W = Nk * 32;

    logic             CS;
    logic             SDI;
    logic             SDO;
    logic [127:0]     core_data;
    logic [KEY_W-1:0] core_key;
    logic             core_start;
    logic             core_done;
    logic [127:0]     core_result;
    logic             busy;
    logic             err;

    modport slave (
        input  CS, SDI, core_done, core_result,
        output SDO, core_data, core_key, core_start, busy, err
    );

    modport master (
        output CS, SDI, core_done, core_result,
        input  SDO, core_data, core_key, core_start, busy, err
    );

endinterface

// File: rtl/spi_shift_reg.sv
// Generic shift register: parallel load has priority over a left shift with serial-in at bit 0.
module spi_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         sin_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], sin_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/spi_aes_slave_frame.sv
// Slave-side SPI frame engine: receives {data,key}, runs the core handshake, returns the result on SDO.
module spi_aes_slave_frame
    import aes_link_pkg::*;
#(
    parameter int unsigned Nk      = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_aes_slave_frame_if.slave bus
);
    localparam int unsigned KEY_W   = Nk * 32;
    localparam int unsigned FRAME_W = frame_w(Nk);
    localparam int unsigned CW      = $clog2(FRAME_W);
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_RX    = RX;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_WAIT  = WAIT_CORE;
    localparam logic [2:0] S_TX    = TX;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               cs_q;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [KEY_W-1:0]   key_q, key_d;

    logic [FRAME_W-1:0] rx_q;
    logic [FRAME_W-1:0] rx_next;
    logic               rx_shift;
    logic [BLOCK_W-1:0] tx_q;
    logic [BLOCK_W-1:0] tx_val;
    logic               tx_load;
    logic               tx_shift;
    logic               cs_rise;
    logic               unused_bits;

    spi_shift_reg #(.W(FRAME_W)) u_rx_sr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (rx_shift),
        .sin_i      (bus.SDI),
        .q_o        (rx_q)
    );

    // tx_sr drains to zero as it shifts, so its MSB doubles as the idle-low SDO.
    spi_shift_reg #(.W(BLOCK_W)) u_tx_sr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_val_i (tx_val),
        .shift_i    (tx_shift),
        .sin_i      (1'b0),
        .q_o        (tx_q)
    );

    // Frame as it will stand once the bit on SDI this cycle is shifted in.
    assign rx_next     = {rx_q[FRAME_W-2:0], bus.SDI};
    assign cs_rise     = bus.CS & ~cs_q;
    assign unused_bits = ^{rx_q[FRAME_W-1], tx_q[BLOCK_W-2:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        start_d  = 1'b0;
        err_d    = err_q;
        data_d   = data_q;
        key_d    = key_q;
        rx_shift = 1'b0;
        tx_load  = 1'b0;
        tx_val   = bus.core_result;
        tx_shift = 1'b0;

        if (cs_rise) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cs_rise) begin
                    state_d = S_RX;
                    cnt_d   = CW'(FRAME_W - 1);
                end
            end
            S_RX: begin
                if (!bus.CS) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    rx_shift = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_START;
                        start_d = 1'b1;
                        data_d  = rx_next[FRAME_W-1:KEY_W];
                        key_d   = rx_next[KEY_W-1:0];
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_START: begin
                if (!bus.CS) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    tcnt_d  = '0;
                end
            end
            S_WAIT: begin
                // A done in the final allowed cycle still beats the timeout.
                if (!bus.CS) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bus.core_done) begin
                    state_d = S_TX;
                    cnt_d   = CW'(BLOCK_W - 1);
                    tx_load = 1'b1;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_TX: begin
                if (!bus.CS) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tx_load = 1'b1;
                    tx_val  = '0;
                end else begin
                    tx_shift = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (!bus.CS) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            cs_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            cs_q    <= bus.CS;
            start_q <= start_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            data_q  <= data_d;
            key_q   <= key_d;
        end
    end

    assign bus.SDO        = tx_q[BLOCK_W-1];
    assign bus.core_data  = data_q;
    assign bus.core_key   = key_q;
    assign bus.core_start = start_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_spi_aes_slave_frame.sv
// Directed bench for spi_aes_slave_frame: Nk=4 and Nk=8 instances sharing SDI and core stimulus.
module tb_spi_aes_slave_frame;

    logic         clk;
    logic         rst;
    logic         cs;
    logic         sdi;
    logic         core_done;
    logic [127:0] core_result;
    logic         big;

    int n_total = 0;
    int n_pass  = 0;
    int n_start = 0;

    localparam logic [127:0] FIPS_DAT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_RES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY8     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RES8     = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C_DAT    = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [255:0] C_KEY    = 256'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C_RES    = 128'hdeadbeef0000000012345678cafef00d;
    localparam logic [127:0] ONES     = {128{1'b1}};

    spi_aes_slave_frame_if #(.Nk(4)) if4 ();
    spi_aes_slave_frame_if #(.Nk(8)) if8 ();

    spi_aes_slave_frame #(.Nk(4), .TIMEOUT(1023)) u4 (.clk(clk), .rst(rst), .bus(if4));
    spi_aes_slave_frame #(.Nk(8), .TIMEOUT(1023)) u8 (.clk(clk), .rst(rst), .bus(if8));

    assign if4.CS          = cs & ~big;
    assign if8.CS          = cs & big;
    assign if4.SDI         = sdi;
    assign if8.SDI         = sdi;
    assign if4.core_done   = core_done;
    assign if8.core_done   = core_done;
    assign if4.core_result = core_result;
    assign if8.core_result = core_result;

    logic         sdo_s, start_s, busy_s, err_s;
    logic [127:0] data_s;
    logic [255:0] key_s;
    assign sdo_s   = big ? if8.SDO        : if4.SDO;
    assign start_s = big ? if8.core_start : if4.core_start;
    assign busy_s  = big ? if8.busy       : if4.busy;
    assign err_s   = big ? if8.err        : if4.err;
    assign data_s  = big ? if8.core_data  : if4.core_data;
    assign key_s   = big ? if8.core_key   : {128'b0, if4.core_key};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (if4.core_start || if8.core_start) n_start++;
    end

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Raise CS, then present nsend bits MSB-first; returns with the last bit on SDI, not yet sampled.
    task automatic send_bits(input logic [383:0] frame, input int fw, input int nsend, input bit spur);
        @(negedge clk);
        cs  = 1'b1;
        sdi = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            @(negedge clk);
            sdi       = frame[fw-1-i];
            core_done = spur && (i == 50);
        end
        core_done = 1'b0;
    endtask

    task automatic run_frame(input logic [127:0] dat, input logic [255:0] key, input int fw,
                             input int delay, input logic [127:0] res, input bit spur);
        logic [383:0] frame;
        logic [127:0] got;
        frame = ({256'b0, dat} << (fw - 128)) | {128'b0, key};
        send_bits(frame, fw, fw, spur);
        check("pre_start", start_s, 1'b0);
        @(negedge clk);
        check("start", start_s, 1'b1);
        check("data", data_s, dat);
        check("key", key_s, key);
        check("err_clr", err_s, 1'b0);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (k == 0) check("start_1cyc", start_s, 1'b0);
        end
        core_result = res;
        core_done   = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        for (int k = 0; k < 128; k++) begin
            got[127-k] = sdo_s;
            core_done  = spur && (k == 60);
            @(negedge clk);
        end
        core_done = 1'b0;
        check("tx", got, res);
        check("done_busy", busy_s, 1'b1);
        check("done_sdo", sdo_s, 1'b0);
        check("done_err", err_s, 1'b0);
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; sdi = 1'b0; core_done = 1'b0; core_result = '0; big = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sdo", if4.SDO, 1'b0);
        check("rst_busy", if4.busy, 1'b0);
        check("rst_err", if4.err, 1'b0);
        check("rst_start", if4.core_start, 1'b0);
        check("rst_data", if4.core_data, 128'b0);
        check("rst_key8", if8.core_key, 256'b0);
        rst = 1'b1;
        @(negedge clk);

        // FIPS-197 Nk=4 with spurious core_done in RX and TX, then CS held in DONE
        run_frame(FIPS_DAT, FIPS_KEY, 256, 10, FIPS_RES, 1'b1);
        repeat (5) @(negedge clk);
        check("hold_busy", busy_s, 1'b1);
        check("hold_nstart", n_start, 1);
        cs = 1'b0;
        @(negedge clk);
        check("idle_busy", busy_s, 1'b0);

        // Nk=8, 384-bit frame
        big = 1'b1;
        @(negedge clk);
        run_frame(FIPS_DAT, KEY8, 384, 3, RES8, 1'b0);
        cs = 1'b0;
        @(negedge clk);
        big = 1'b0;

        // CS lost after 100 bits, then a clean frame
        send_bits({128'b0, C_DAT, C_KEY[127:0]}, 256, 100, 1'b0);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        check("abort_err", err_s, 1'b1);
        check("abort_busy", busy_s, 1'b0);
        check("abort_data", data_s, FIPS_DAT);
        check("abort_nstart", n_start, 2);
        run_frame(C_DAT, C_KEY, 256, 5, C_RES, 1'b0);
        cs = 1'b0;
        @(negedge clk);

        // Core never answers
        send_bits({128'b0, FIPS_DAT, FIPS_KEY[127:0]}, 256, 256, 1'b0);
        @(negedge clk);
        check("to_start", start_s, 1'b1);
        repeat (1023) @(negedge clk);
        check("to_pre_err", err_s, 1'b0);
        @(negedge clk);
        check("to_err", err_s, 1'b1);
        check("to_busy", busy_s, 1'b1);
        cs = 1'b0;
        @(negedge clk);
        check("to_sticky", err_s, 1'b1);

        // core_done in the timeout cycle wins, then reset behaviour mid-TX
        send_bits({128'b0, FIPS_DAT, FIPS_KEY[127:0]}, 256, 256, 1'b0);
        @(negedge clk);
        repeat (1023) @(negedge clk);
        core_result = ONES;
        core_done   = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("edge_err", err_s, 1'b0);
        check("edge_sdo", sdo_s, 1'b1);
        check("edge_busy", busy_s, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("glitch_busy", busy_s, 1'b1);
        check("glitch_sdo", sdo_s, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_sdo", sdo_s, 1'b0);
        check("rst_tx_busy", busy_s, 1'b0);
        check("rst_tx_err", err_s, 1'b0);
        rst = 1'b1;
        cs  = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
